// File: rtl/pn_pkg.sv
// Shared helpers for the Petri-net token pipeline: width functions,
// the per-place update encoding and a default place-count type.
package pn_pkg;

  // Ceiling log2 usable in constant expressions; pn_clog2(1) == 0.
  function automatic int pn_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Width of one place counter holding 0..cap tokens.
  function automatic int pn_cnt_w(input int cap);
    return pn_clog2(cap + 1);
  endfunction

  // Width of the pipeline-wide token total, 0..depth*cap tokens.
  function automatic int pn_total_w(input int depth, input int cap);
    return pn_clog2(depth * cap + 1);
  endfunction

  // Place counter type for the default single-token (safe) configuration.
  localparam int PN_DEFAULT_CAP = 1;
  localparam int PN_PLACE_W     = pn_cnt_w(PN_DEFAULT_CAP);
  typedef logic [PN_PLACE_W-1:0] place_cnt_t;

  // What a place does to its marking on the next clock edge.
  //   PLACE_HOLD : no change (nothing in/out, or one in and one out)
  //   PLACE_INC  : one token arrives, none leaves, room available
  //   PLACE_DEC  : one token leaves, none arrives
  //   PLACE_SAT  : one token arrives at a full place and is lost
  typedef enum logic [1:0] {
    PLACE_HOLD = 2'b00,
    PLACE_INC  = 2'b01,
    PLACE_DEC  = 2'b10,
    PLACE_SAT  = 2'b11
  } place_op_e;

endpackage

// File: rtl/pn_place.sv
// One CAP-bounded Petri-net place. add/sub are the firings of the input and
// output transitions; the place never goes below zero because the output
// transition is only enabled while the place is nonempty.
module pn_place
  import pn_pkg::*;
#(
  parameter int CAP = 1,
  parameter int CW  = pn_cnt_w(CAP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          add,
  input  logic          sub,
  output logic [CW-1:0] m,
  output logic          nonempty,
  output logic          has_room,
  output logic          sat_evt
);

  localparam logic [CW-1:0] FULL = CW'(CAP);

  place_op_e op;

  // Classify this cycle's firings into a single marking update.
  always_comb begin
    // NOTE: op gets its default first so every path assigns it and no latch is inferred.
    op = PLACE_HOLD;
    if (add && !sub) begin
      op = (m == FULL) ? PLACE_SAT : PLACE_INC;
    end else if (sub && !add) begin
      op = PLACE_DEC;
    end
  end

  assign nonempty = (m != '0);
  assign has_room = (m < FULL);
  assign sat_evt  = (op == PLACE_SAT);

  // Marking register; a saturating arrival leaves the count at CAP.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the marking is cleared asynchronously, so a mid-stream reset drops in-flight tokens at once.
    if (rst) begin
      m <= '0;
    end else begin
      // NOTE: non-blocking updates make every place see the same pre-edge marking.
      case (op)
        PLACE_INC: m <= m + CW'(1);
        PLACE_DEC: m <= m - CW'(1);
        default:   m <= m;
      endcase
    end
  end

endmodule

// File: rtl/pn_token_pipeline.sv
// Petri-net token pipeline: an N_IN-way join transition t0 feeds a linear
// chain of DEPTH counting places; the last place is drained by out_take.
// All transition enables come from the registered marking only, so tokens
// advance at most one place per cycle and there is no combinational credit
// path along the chain.
module pn_token_pipeline
  import pn_pkg::*;
#(
  parameter int N_IN      = 2,
  parameter int DEPTH     = 10,
  parameter int CAP       = 1,
  parameter int SAFE_MODE = 1,
  localparam int TCW      = pn_total_w(DEPTH, CAP)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in_valid,
  output logic [N_IN-1:0] in_ready,
  input  logic            out_take,
  output logic            out_valid,
  output logic [DEPTH-1:0] marked,
  output logic [TCW-1:0]  token_count,
  output logic            overflow
);

  localparam int CW            = pn_cnt_w(CAP);
  // Blocking rule: a transition also needs room in its postset place.
  localparam bit BLOCKING_RULE = (SAFE_MODE != 0);

  // fire[k] is transition t_k; fire[DEPTH] is the output transition tout.
  logic [DEPTH:0]   fire;
  logic [DEPTH-1:0] nonempty;
  logic [DEPTH-1:0] has_room;
  logic [DEPTH-1:0] sat_evt;
  logic [CW-1:0]    place_m [DEPTH];
  logic [TCW-1:0]   lost_cnt;
  logic [TCW-1:0]   token_count_nxt;

  // Place k is filled by t_k and emptied by t_{k+1}.
  for (genvar k = 0; k < DEPTH; k++) begin : g_place
    pn_place #(
      .CAP (CAP),
      .CW  (CW)
    ) u_place (
      .clk      (clk),
      .rst      (rst),
      .add      (fire[k]),
      .sub      (fire[k+1]),
      .m        (place_m[k]),
      .nonempty (nonempty[k]),
      .has_room (has_room[k]),
      .sat_evt  (sat_evt[k])
    );
  end

  // Transition enables; every enabled transition fires in the same cycle.
  always_comb begin
    fire    = '0;
    // The join fires only when every channel offers a token.
    fire[0] = (&in_valid) && (has_room[0] || !BLOCKING_RULE);
    for (int k = 1; k < DEPTH; k++) begin
      fire[k] = nonempty[k-1] && (has_room[k] || !BLOCKING_RULE);
    end
    // A take against an empty output place is simply ignored.
    fire[DEPTH] = out_take && nonempty[DEPTH-1];
  end

  // All channels are consumed together, or none of them.
  assign in_ready = {N_IN{fire[0]}};

  // Marking view derived from the place counters.
  always_comb begin
    marked = '0;
    for (int k = 0; k < DEPTH; k++) begin
      marked[k] = (place_m[k] != '0);
    end
  end

  assign out_valid = marked[DEPTH-1];

  // Tokens destroyed this cycle by arrivals at full places.
  always_comb begin
    lost_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lost_cnt = lost_cnt + TCW'(sat_evt[k]);
    end
  end

  assign token_count_nxt = token_count + TCW'(fire[0]) - TCW'(fire[DEPTH]) - lost_cnt;

  // Running token total and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      token_count <= '0;
      overflow    <= 1'b0;
    end else begin
      token_count <= token_count_nxt;
      // Saturation cannot happen under the blocking rule; the flag stays 0 there.
      if (!BLOCKING_RULE && (|sat_evt)) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pn_token_pipeline.sv
// Directed bench for pn_token_pipeline. Three instances share clk/rst:
//   dut_s : DEPTH=4 CAP=1 SAFE_MODE=1
//   dut_c : DEPTH=4 CAP=2 SAFE_MODE=1
//   dut_u : DEPTH=4 CAP=1 SAFE_MODE=0
// Inputs change 1ns after a rising edge; outputs are read at least 1ns later.
module tb_pn_token_pipeline;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0] s_in_valid = '0, s_in_ready;
  logic       s_out_take = 1'b0, s_out_valid, s_overflow;
  logic [3:0] s_marked;
  logic [2:0] s_token_count;

  logic [1:0] c_in_valid = '0, c_in_ready;
  logic       c_out_take = 1'b0, c_out_valid, c_overflow;
  logic [3:0] c_marked;
  logic [3:0] c_token_count;

  logic [1:0] u_in_valid = '0, u_in_ready;
  logic       u_out_take = 1'b0, u_out_valid, u_overflow;
  logic [3:0] u_marked;
  logic [2:0] u_token_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pn_token_pipeline #(.N_IN(2), .DEPTH(4), .CAP(1), .SAFE_MODE(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_take(s_out_take), .out_valid(s_out_valid), .marked(s_marked),
    .token_count(s_token_count), .overflow(s_overflow)
  );

  pn_token_pipeline #(.N_IN(2), .DEPTH(4), .CAP(2), .SAFE_MODE(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_take(c_out_take), .out_valid(c_out_valid), .marked(c_marked),
    .token_count(c_token_count), .overflow(c_overflow)
  );

  pn_token_pipeline #(.N_IN(2), .DEPTH(4), .CAP(1), .SAFE_MODE(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .out_take(u_out_take), .out_valid(u_out_valid), .marked(u_marked),
    .token_count(u_token_count), .overflow(u_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_s_out_valid: got %b, expected 0", s_out_valid); end
    n_vec++; if (s_marked !== 4'b0000) begin n_err++; $display("FAIL reset_s_marked: got %b, expected 0000", s_marked); end
    n_vec++; if (s_token_count !== 3'd0) begin n_err++; $display("FAIL reset_s_token_count: got %0d, expected 0", s_token_count); end
    n_vec++; if (s_overflow !== 1'b0) begin n_err++; $display("FAIL reset_s_overflow: got %b, expected 0", s_overflow); end
    n_vec++; if (c_token_count !== 4'd0) begin n_err++; $display("FAIL reset_c_token_count: got %0d, expected 0", c_token_count); end
    n_vec++; if (u_overflow !== 1'b0) begin n_err++; $display("FAIL reset_u_overflow: got %b, expected 0", u_overflow); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic drain_s();
    int guard;
    guard = 0;
    s_out_take = 1'b1;
    while (s_token_count !== 3'd0 && guard < 50) begin
      tick();
      guard++;
    end
    s_out_take = 1'b0;
    n_vec++; if (s_token_count !== 3'd0) begin n_err++; $display("FAIL drain_s: got %0d tokens, expected 0", s_token_count); end
  endtask

  task automatic test_single_token();
    s_in_valid = 2'b11;
    #1;
    n_vec++; if (s_in_ready !== 2'b11) begin n_err++; $display("FAIL single_in_ready: got %b, expected 11", s_in_ready); end
    tick();
    s_in_valid = 2'b00;
    n_vec++; if (s_token_count !== 3'd1) begin n_err++; $display("FAIL single_count_early: got %0d, expected 1", s_token_count); end
    tick();
    tick();
    n_vec++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL single_latency_early: got %b, expected 0", s_out_valid); end
    tick();
    n_vec++; if (s_out_valid !== 1'b1) begin n_err++; $display("FAIL single_latency: got %b, expected 1", s_out_valid); end
    n_vec++; if (s_marked !== 4'b1000) begin n_err++; $display("FAIL single_marked: got %b, expected 1000", s_marked); end
    n_vec++; if (s_token_count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d, expected 1", s_token_count); end
    s_out_take = 1'b1;
    tick();
    s_out_take = 1'b0;
    n_vec++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL single_take_valid: got %b, expected 0", s_out_valid); end
    n_vec++; if (s_token_count !== 3'd0) begin n_err++; $display("FAIL single_take_count: got %0d, expected 0", s_token_count); end
    // Takes against an empty output place must be ignored.
    s_out_take = 1'b1;
    repeat (3) tick();
    s_out_take = 1'b0;
    n_vec++; if (s_token_count !== 3'd0) begin n_err++; $display("FAIL empty_take_count: got %0d, expected 0", s_token_count); end
    n_vec++; if (s_marked !== 4'b0000) begin n_err++; $display("FAIL empty_take_marked: got %b, expected 0000", s_marked); end
  endtask

  task automatic test_join();
    s_in_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if (s_in_ready !== 2'b00) begin n_err++; $display("FAIL join_partial_ready[%0d]: got %b, expected 00", i, s_in_ready); end
      tick();
      n_vec++; if (s_token_count !== 3'd0) begin n_err++; $display("FAIL join_partial_count[%0d]: got %0d, expected 0", i, s_token_count); end
    end
    s_in_valid = 2'b11;
    #1;
    n_vec++; if (s_in_ready !== 2'b11) begin n_err++; $display("FAIL join_full_ready: got %b, expected 11", s_in_ready); end
    tick();
    s_in_valid = 2'b00;
    n_vec++; if (s_token_count !== 3'd1) begin n_err++; $display("FAIL join_full_count: got %0d, expected 1", s_token_count); end
    drain_s();
  endtask

  task automatic test_back_pressure();
    int deliveries;
    int non_toggle;
    logic prev_valid;
    s_in_valid = 2'b11;
    repeat (12) tick();
    #1;
    n_vec++; if (s_token_count !== 3'd4) begin n_err++; $display("FAIL bp_count: got %0d, expected 4", s_token_count); end
    n_vec++; if (s_in_ready !== 2'b00) begin n_err++; $display("FAIL bp_in_ready: got %b, expected 00", s_in_ready); end
    n_vec++; if (s_overflow !== 1'b0) begin n_err++; $display("FAIL bp_overflow: got %b, expected 0", s_overflow); end
    n_vec++; if (s_marked !== 4'b1111) begin n_err++; $display("FAIL bp_marked: got %b, expected 1111", s_marked); end
    s_out_take = 1'b1;
    deliveries = 0;
    non_toggle = 0;
    prev_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (i > 0 && s_out_valid === prev_valid) non_toggle++;
      if (s_out_valid === 1'b1) deliveries++;
      prev_valid = s_out_valid;
      tick();
    end
    n_vec++; if (deliveries != 10) begin n_err++; $display("FAIL bp_throughput: got %0d tokens in 20 cycles, expected 10", deliveries); end
    n_vec++; if (non_toggle != 0) begin n_err++; $display("FAIL bp_toggle: got %0d non-toggling cycles, expected 0", non_toggle); end
    s_in_valid = 2'b00;
    drain_s();
  endtask

  task automatic test_cap2();
    int guard;
    c_in_valid = 2'b11;
    c_out_take = 1'b1;
    #1;
    n_vec++; if (c_in_ready !== 2'b11) begin n_err++; $display("FAIL cap2_in_ready0: got %b, expected 11", c_in_ready); end
    repeat (3) tick();
    n_vec++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL cap2_latency_early: got %b, expected 0", c_out_valid); end
    tick();
    n_vec++; if (c_out_valid !== 1'b1) begin n_err++; $display("FAIL cap2_latency: got %b, expected 1", c_out_valid); end
    n_vec++; if (c_token_count !== 4'd4) begin n_err++; $display("FAIL cap2_fill_count: got %0d, expected 4", c_token_count); end
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      n_vec++; if (c_out_valid !== 1'b1) begin n_err++; $display("FAIL cap2_valid[%0d]: got %b, expected 1", i, c_out_valid); end
      n_vec++; if (c_in_ready !== 2'b11) begin n_err++; $display("FAIL cap2_ready[%0d]: got %b, expected 11", i, c_in_ready); end
      n_vec++; if (c_token_count !== 4'd4) begin n_err++; $display("FAIL cap2_count[%0d]: got %0d, expected 4", i, c_token_count); end
    end
    n_vec++; if (c_marked !== 4'b1111) begin n_err++; $display("FAIL cap2_marked: got %b, expected 1111", c_marked); end
    n_vec++; if (c_overflow !== 1'b0) begin n_err++; $display("FAIL cap2_overflow: got %b, expected 0", c_overflow); end
    c_in_valid = 2'b00;
    guard = 0;
    while (c_token_count !== 4'd0 && guard < 50) begin
      tick();
      guard++;
    end
    c_out_take = 1'b0;
    n_vec++; if (c_token_count !== 4'd0) begin n_err++; $display("FAIL cap2_drain: got %0d tokens, expected 0", c_token_count); end
  endtask

  task automatic test_overflow();
    int guard;
    u_in_valid = 2'b11;
    u_out_take = 1'b0;
    #1;
    n_vec++; if (u_in_ready !== 2'b11) begin n_err++; $display("FAIL ovf_in_ready: got %b, expected 11", u_in_ready); end
    repeat (4) tick();
    n_vec++; if (u_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_before: got %b, expected 0", u_overflow); end
    n_vec++; if (u_token_count !== 3'd4) begin n_err++; $display("FAIL ovf_fill_count: got %0d, expected 4", u_token_count); end
    n_vec++; if (u_marked !== 4'b1111) begin n_err++; $display("FAIL ovf_fill_marked: got %b, expected 1111", u_marked); end
    tick();
    n_vec++; if (u_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b, expected 1", u_overflow); end
    n_vec++; if (u_token_count !== 3'd4) begin n_err++; $display("FAIL ovf_lost_count: got %0d, expected 4", u_token_count); end
    repeat (5) tick();
    n_vec++; if (u_token_count !== 3'd4) begin n_err++; $display("FAIL ovf_steady_count: got %0d, expected 4", u_token_count); end
    n_vec++; if (u_out_valid !== 1'b1) begin n_err++; $display("FAIL ovf_out_valid: got %b, expected 1", u_out_valid); end
    u_in_valid = 2'b00;
    u_out_take = 1'b1;
    guard = 0;
    while (u_token_count !== 3'd0 && guard < 50) begin
      tick();
      guard++;
    end
    u_out_take = 1'b0;
    n_vec++; if (u_token_count !== 3'd0) begin n_err++; $display("FAIL ovf_drain: got %0d tokens, expected 0", u_token_count); end
    n_vec++; if (u_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b, expected 1", u_overflow); end
  endtask

  task automatic test_async_reset();
    s_in_valid = 2'b11;
    s_out_take = 1'b0;
    repeat (6) tick();
    @(posedge clk);
    #3;
    s_in_valid = 2'b00;
    rst = 1'b1;
    #1;
    n_vec++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL areset_out_valid: got %b, expected 0", s_out_valid); end
    n_vec++; if (s_marked !== 4'b0000) begin n_err++; $display("FAIL areset_marked: got %b, expected 0000", s_marked); end
    n_vec++; if (s_token_count !== 3'd0) begin n_err++; $display("FAIL areset_count: got %0d, expected 0", s_token_count); end
    n_vec++; if (u_overflow !== 1'b0) begin n_err++; $display("FAIL areset_overflow: got %b, expected 0", u_overflow); end
    #1;
    rst = 1'b0;
    tick();
    s_in_valid = 2'b11;
    tick();
    s_in_valid = 2'b00;
    tick();
    tick();
    n_vec++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_early: got %b, expected 0", s_out_valid); end
    tick();
    n_vec++; if (s_out_valid !== 1'b1) begin n_err++; $display("FAIL post_reset_latency: got %b, expected 1", s_out_valid); end
    n_vec++; if (s_token_count !== 3'd1) begin n_err++; $display("FAIL post_reset_count: got %0d, expected 1", s_token_count); end
  endtask

  initial begin
    test_reset();
    test_single_token();
    test_join();
    test_back_pressure();
    test_cap2();
    test_overflow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
